// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port I/D arbiter in front of the shared block data memory
// Optional build macro: MEM_ARB_DPORT_PRIORITY_EN (port D wins every tie; default is round-robin)
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic [1:0]        grant
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    REL_I  = 3'd3,
    REL_D  = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   first_q;
  logic   req_i;
  logic   req_d;
  logic   pick_d;
  logic   done;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  // The memory may not have raised its busywait yet during our first BUSY cycle,
  // so completion is only trusted once that cycle has passed.
  assign done = ~first_q & ~mem_busywait;

  assign i_busywait = req_i & (state_q != REL_I);
  assign d_busywait = req_d & (state_q != REL_D);

`ifdef MEM_ARB_DPORT_PRIORITY_EN
  assign pick_d = req_d;
`else
  logic last_d_q;

  assign pick_d = req_d & (~req_i | ~last_d_q);

  // Remember which port finished last so a tie goes to the other one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_d_q <= 1'b1;
    end else if (state_q == BUSY_I && done) begin
      last_d_q <= 1'b0;
    end else if (state_q == BUSY_D && done) begin
      last_d_q <= 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for memory in BUSY, one release cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i | req_d) begin
          state_d = pick_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I: begin
        if (done) begin
          state_d = REL_I;
        end
      end
      BUSY_D: begin
        if (done) begin
          state_d = REL_D;
        end
      end
      REL_I:   state_d = IDLE;
      REL_D:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side strobes, captured request, grant and per-port read data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      first_q       <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
      grant         <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i | req_d) begin
            first_q <= 1'b1;
            if (pick_d) begin
              mem_write     <= d_write;
              mem_read      <= ~d_write;
              mem_address   <= d_address;
              mem_writedata <= d_writedata;
              grant         <= 2'b10;
            end else begin
              mem_write   <= 1'b0;
              mem_read    <= 1'b1;
              mem_address <= i_address;
              grant       <= 2'b01;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          first_q <= 1'b0;
          if (done) begin
            if (mem_read) begin
              if (state_q == BUSY_I) begin
                i_readdata <= mem_readdata;
              end else begin
                d_readdata <= mem_readdata;
              end
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        REL_I, REL_D: begin
          grant <= 2'b00;
        end
        default: begin
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter
module tb_mem_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;
  logic [1:0]        grant;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_array [64];
  logic [31:0] ref_mem   [64];
  int          lat_cfg = 0;
  bit          rnd_lat = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .grant(grant)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Data memory: busywait high for the configured latency once a strobe is seen,
  // then data is presented (read) or the array is written (write).
  initial begin
    int rem;
    bit started;
    bit wrote;
    rem = 0;
    started = 0;
    wrote = 0;
    mem_busywait = 1'b0;
    mem_readdata = '0;
    forever begin
      @(posedge CLK);
      #3;
      if (mem_read === 1'b1 || mem_write === 1'b1) begin
        if (!started) begin
          started = 1;
          wrote = 0;
          rem = rnd_lat ? int'($urandom_range(0, 4)) : lat_cfg;
        end
        if (rem > 0) begin
          mem_busywait = 1'b1;
          mem_readdata = $urandom;
          rem--;
        end else begin
          mem_busywait = 1'b0;
          if (mem_write) begin
            if (!wrote) mem_array[mem_address] = mem_writedata;
            wrote = 1;
          end else begin
            mem_readdata = mem_array[mem_address];
          end
        end
      end else begin
        started = 0;
        mem_busywait = 1'b0;
      end
    end
  end

  // One isolated transaction; exp_wait is the number of sampled cycles with busywait high.
  task automatic do_txn(input bit port_d, input bit wr, input logic [5:0] addr,
                        input logic [31:0] wdata, input int lat, input int exp_wait);
    int n;
    logic [31:0] d_prev;
    d_prev = d_readdata;
    lat_cfg = lat;
    if (port_d) begin
      d_write = wr; d_read = ~wr; d_address = addr; d_writedata = wdata;
    end else begin
      i_read = 1'b1; i_address = addr;
    end
    #1;
    check("busy_rise", port_d ? d_busywait : i_busywait, 1);
    n = 0;
    forever begin
      @(posedge CLK); #1;
      if (!(port_d ? d_busywait : i_busywait)) break;
      n++;
      if (n > 100) begin
        check("txn_timeout", 0, 1);
        break;
      end
      check("busy_mem_read", mem_read, !wr);
      check("busy_mem_write", mem_write, wr);
      check("busy_mem_addr", mem_address, addr);
      if (wr) check("busy_mem_wdata", mem_writedata, wdata);
      check("busy_grant", grant, port_d ? 2'b10 : 2'b01);
      check("busy_other_bw", port_d ? i_busywait : d_busywait, 0);
    end
    check("wait_cycles", n, exp_wait);
    check("rel_strobes", {mem_read, mem_write}, 0);
    if (wr) begin
      check("wr_keeps_rdata", d_readdata, d_prev);
      ref_mem[addr] = wdata;
    end else begin
      check("rel_rdata", port_d ? d_readdata : i_readdata, ref_mem[addr]);
    end
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    @(posedge CLK); #1;
    check("idle_grant", grant, 0);
    check("idle_bw", {i_busywait, d_busywait}, 0);
    check("idle_addr_hold", mem_address, addr);
    if (wr) check("mem_written", mem_array[addr], wdata);
  endtask

  logic [1:0]  gseq [4];
  logic [1:0]  prev_g;
  int          ng;
  bit          found;
  bit          i_act, d_act, i_was, d_was, dw;
  logic [5:0]  ia, da;
  logic [31:0] dwd, d_last, v;
  int          wi, wd, n_done, bad;

  initial begin
    RESET = 1'b1;
    i_read = 0; i_address = 0;
    d_read = 0; d_write = 0; d_address = 0; d_writedata = 0;
    for (int k = 0; k < 64; k++) begin
      v = $urandom;
      mem_array[k] = v;
      ref_mem[k] = v;
    end

    // Reset
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("rst_strobes", {mem_read, mem_write}, 0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_writedata, 0);
    check("rst_grant", grant, 0);
    check("rst_i_rdata", i_readdata, 0);
    check("rst_d_rdata", d_readdata, 0);
    check("rst_bw", {i_busywait, d_busywait}, 0);

    // Lone I read, lone D write, minimum-latency cases
    mem_array[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    do_txn(0, 0, 6'h05, 32'h0, 5, 6);
    check("i_rdata_holds", i_readdata, 32'hDEADBEEF);
    do_txn(1, 1, 6'h3F, 32'h01020304, 3, 4);
    do_txn(0, 0, 6'h0A, 32'h0, 0, 2);
    do_txn(1, 0, 6'h3F, 32'h0, 1, 2);
    check("i_rdata_after_d", i_readdata, ref_mem[10]);

    // Simultaneous held requests: grant order
    lat_cfg = 2;
    i_read = 1; i_address = 6'h01;
    d_read = 1; d_address = 6'h02;
    ng = 0; prev_g = 2'b00;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      @(posedge CLK); #1;
      if (grant != 2'b00 && prev_g == 2'b00) begin
        gseq[ng] = grant;
        ng++;
      end
      prev_g = grant;
    end
    check("tie_grants_seen", ng, 4);
`ifdef MEM_ARB_DPORT_PRIORITY_EN
    for (int k = 0; k < 4; k++) check("tie_order", gseq[k], 2'b10);
`else
    for (int k = 0; k < 4; k++) check("tie_order", gseq[k], k[0] ? 2'b10 : 2'b01);
`endif
    i_read = 0; d_read = 0;
    found = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge CLK); #1;
      if (grant == 2'b00) begin found = 1; break; end
    end
    check("tie_drain", found, 1);
    @(posedge CLK); #1;

    // Reset in the third BUSY_D cycle of a write
    lat_cfg = 10;
    d_write = 1; d_address = 6'h11; d_writedata = 32'h5A5A5A5A;
    repeat (3) begin @(posedge CLK); #1; end
    check("pre_rst_write", mem_write, 1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("mid_rst_write", mem_write, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_addr", mem_address, 0);
    check("mid_rst_no_rel", d_busywait, 1);
    check("mid_rst_rdata", {i_readdata, d_readdata} == 64'h0, 1);
    RESET = 1'b0; d_write = 0;
    @(posedge CLK); #1;
    check("post_rst_idle", {grant, d_busywait}, 0);
    check("post_rst_unwritten", mem_array[6'h11], ref_mem[6'h11]);

    // Withdraw I during BUSY, D waiting behind it
    lat_cfg = 4;
    mem_array[7] = 32'hCAFE0007; ref_mem[7] = 32'hCAFE0007;
    i_read = 1; i_address = 6'h07;
    repeat (2) begin @(posedge CLK); #1; end
    i_read = 0; d_read = 1; d_address = 6'h09;
    #1;
    check("wd_i_bw", i_busywait, 0);
    check("wd_d_bw", d_busywait, 1);
    found = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge CLK); #1;
      if (i_readdata === ref_mem[7]) begin found = 1; break; end
    end
    check("wd_i_done", found, 1);
    check("wd_d_still_bw", d_busywait, 1);
    @(posedge CLK); #1;
    check("wd_idle_gap", grant, 0);
    @(posedge CLK); #1;
    check("wd_d_grant", grant, 2'b10);
    check("wd_d_read", mem_read, 1);
    check("wd_d_addr", mem_address, 6'h09);
    found = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge CLK); #1;
      if (!d_busywait) begin found = 1; break; end
    end
    check("wd_d_done", found, 1);
    check("wd_d_rdata", d_readdata, ref_mem[9]);
    d_read = 0;
    d_last = ref_mem[9];
    @(posedge CLK); #1;

    // Randomized concurrent traffic against the memory model
    rnd_lat = 1;
    i_act = 0; d_act = 0; wi = 0; wd = 0; n_done = 0;
    ia = 0; da = 0; dw = 0; dwd = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(posedge CLK); #1;
      i_was = i_act; d_was = d_act;
      if (i_act && !i_busywait) begin
        check("rnd_i_data", i_readdata, ref_mem[ia]);
        i_act = 0; i_read = 0; wi = 0; n_done++;
        if (d_was) wd++;
`ifndef MEM_ARB_DPORT_PRIORITY_EN
        check("rnd_d_starve", wd > 1, 0);
`endif
      end
      if (d_act && !d_busywait) begin
        if (dw) begin
          ref_mem[da] = dwd;
          check("rnd_d_keep", d_readdata, d_last);
        end else begin
          check("rnd_d_data", d_readdata, ref_mem[da]);
          d_last = ref_mem[da];
        end
        d_act = 0; d_read = 0; d_write = 0; wd = 0; n_done++;
        if (i_was) wi++;
`ifndef MEM_ARB_DPORT_PRIORITY_EN
        check("rnd_i_starve", wi > 1, 0);
`endif
      end
      if (cyc < 700) begin
        if (!i_act && $urandom_range(0, 2) != 0) begin
          ia = 6'($urandom_range(0, 63));
          i_address = ia; i_read = 1; i_act = 1;
        end
        if (!d_act && $urandom_range(0, 2) != 0) begin
          da = 6'($urandom_range(0, 63));
          dw = 1'($urandom_range(0, 1));
          dwd = $urandom;
          d_address = da; d_writedata = dwd; d_write = dw;
          d_read = dw ? 1'($urandom_range(0, 1)) : 1'b1;
          d_act = 1;
        end
      end else if (!i_act && !d_act) begin
        break;
      end
    end
    check("rnd_drained", {i_act, d_act}, 0);
    check("rnd_enough_txns", n_done >= 40, 1);
    bad = 0;
    for (int k = 0; k < 64; k++) if (mem_array[k] !== ref_mem[k]) bad++;
    check("rnd_mem_image", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
